ts_adc_accum: RTL and testbench
===============================

TS_ADC_ACCUM -- requirements
Module: ts_adc_accum

Interface
REQ-001 Parameter numCols, default 8: number of QR-accelerator columns served.
REQ-002 Parameter numAdcBits, default 4: ADC resolution per column.
REQ-003 Parameter numInBits, default 4: bit-serial activation bits per frame.
REQ-004 Localparam compCount = 2**numAdcBits-1; localparam accWidth = numAdcBits+numInBits.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 ADC_OUT  input  compCount*numCols  thermometer codes; column j occupies bits [j*compCount +: compCount].
REQ-008 ADC_VALID  input  1  ADC_OUT holds one bit-plane sample this cycle.
REQ-009 ADC_READY  output  1  block accepts a sample this cycle.
REQ-010 SIGNED_IN  input  1  1 = activations are two's complement (MSB plane weighted negative).
REQ-011 CLR  input  1  synchronous frame abort.
REQ-012 RESULT  output  accWidth*numCols  signed per-column frame sums; column j at [j*accWidth +: accWidth].
REQ-013 RESULT_VALID  output  1  RESULT holds an unconsumed frame.
REQ-014 RESULT_READY  input  1  downstream consumes RESULT when RESULT_VALID is high.
REQ-015 THERM_ERR  output  1  sticky flag: a non-monotonic thermometer code was accepted.

Function
REQ-016 A sample is accepted when ADC_VALID and ADC_READY are both high at a rising edge.
REQ-017 Decode per column: value = popcount(code) - 2**(numAdcBits-1), signed numAdcBits (15 ones -> +7, 0 ones -> -8).
REQ-018 Non-monotonic code (a 1 above a 0) is still decoded by popcount; THERM_ERR sets and stays set until RST.
REQ-019 Bit counter k runs 0..numInBits-1; sample k carries weight 2**k, LSB plane first.
REQ-020 When SIGNED_IN is high at sample k = numInBits-1, that sample's weighted value is subtracted; otherwise all planes add.
REQ-021 On sample k = 0, the accumulator loads the weighted value instead of adding it.
REQ-022 Accumulation is exact in accWidth bits; no saturation or overflow is possible for any input.
REQ-023 State machine: ACCUM (collecting samples) and STALL (frame complete, result register still occupied).
REQ-024 On sample k = numInBits-1: if the result register is free or is consumed in the same cycle, the final sum is copied to RESULT, RESULT_VALID goes high next cycle, and k wraps to 0 (remain ACCUM).
REQ-025 If the result register is occupied and not consumed in that cycle, the final sum is kept in the accumulator and the state moves to STALL.
REQ-026 ADC_READY = 1 in ACCUM; ADC_READY = 0 in STALL.
REQ-027 In STALL, on RESULT_READY the held sum moves to RESULT, RESULT_VALID stays high, and the state returns to ACCUM with k = 0.
REQ-028 RESULT_VALID falls the cycle after RESULT_READY is sampled high, unless a new frame is loaded in that same cycle.
REQ-029 RESULT and RESULT_VALID are stable while RESULT_VALID = 1 and RESULT_READY = 0.
REQ-030 Frame-to-result latency: RESULT_VALID rises one cycle after the final accepted sample.
REQ-031 CLR resets k to 0, clears the accumulator, and returns to ACCUM.
REQ-032 CLR does not alter RESULT or RESULT_VALID.
REQ-033 If CLR and an accepted sample coincide, CLR wins and the sample is discarded.
REQ-034 SIGNED_IN is sampled per accepted sample; changing it mid-frame is legal but affects only the MSB plane.

Reset
REQ-035 RST asserted (asynchronously) forces: state ACCUM, k = 0, accumulator 0, RESULT 0, RESULT_VALID 0, THERM_ERR 0.
REQ-036 After RST, ADC_READY reads 1.
REQ-037 RST mid-frame discards all partial sums; the first accepted sample after release has k = 0.

Verification
REQ-038 Unsigned mode, all columns fed 15 ones for 4 planes -> every RESULT column = 7*15 = 105; RESULT_VALID rises 1 cycle after the 4th sample.
REQ-039 Signed mode, all-zero codes (-8) on every plane -> RESULT = -8*7 + 64 = 8; with 15 ones on planes 0-2 and all-zero on plane 3 -> 49 + 64 = 113.
REQ-040 RESULT_READY held low across two full frames -> second frame enters STALL, ADC_READY = 0, RESULT unchanged; one RESULT_READY pulse -> second sum appears and ADC_READY returns to 1.
REQ-041 Code 0b000000011111111 (8 ones) on every plane -> RESULT 0; code with bit 14 = 1 and bit 0 = 0 -> THERM_ERR = 1, which persists until RST.
REQ-042 CLR after 2 samples, then 4 samples of +7 (unsigned) -> RESULT = 105 with no residue from the aborted frame; CLR coinciding with a sample -> that sample is ignored.
REQ-043 RST pulsed mid-frame with RESULT_VALID = 1 -> RESULT_VALID = 0, RESULT = 0, and the next frame computes correctly.

Source files
------------

// File: rtl/ts_adc_accum.sv
// Bit-serial ADC accumulator: decodes per-column thermometer codes and sums
// shift-weighted bit planes into a signed per-column frame result.

module ts_adc_lane #(
  parameter int numAdcBits = 4,
  parameter int numInBits  = 4,
  parameter int kWidth     = 2,
  localparam int compCount = 2**numAdcBits-1,
  localparam int accWidth  = numAdcBits+numInBits
) (
  input  logic [compCount-1:0] code,
  input  logic [accWidth-1:0]  acc,
  input  logic [kWidth-1:0]    k,
  input  logic                 first,
  input  logic                 sub,
  output logic [accWidth-1:0]  nxt,
  output logic                 err
);
  logic [numAdcBits-1:0] cnt, dec;
  logic [accWidth-1:0]   wv, base;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < compCount; i++) cnt = cnt + numAdcBits'(code[i]);
    // popcount minus half-scale is just the popcount with its MSB flipped
    dec  = {~cnt[numAdcBits-1], cnt[numAdcBits-2:0]};
    wv   = {{numInBits{dec[numAdcBits-1]}}, dec} << k;
    base = first ? '0 : acc;
    nxt  = sub ? base - wv : base + wv;
  end

  // a 1 sitting directly above a 0 breaks the thermometer ordering
  assign err = |(code[compCount-1:1] & ~code[compCount-2:0]);
endmodule

module ts_adc_accum #(
  parameter int numCols    = 8,
  parameter int numAdcBits = 4,
  parameter int numInBits  = 4,
  localparam int compCount = 2**numAdcBits-1,
  localparam int accWidth  = numAdcBits+numInBits
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [compCount*numCols-1:0]  ADC_OUT,
  input  logic                          ADC_VALID,
  output logic                          ADC_READY,
  input  logic                          SIGNED_IN,
  input  logic                          CLR,
  output logic [accWidth*numCols-1:0]   RESULT,
  output logic                          RESULT_VALID,
  input  logic                          RESULT_READY,
  output logic                          THERM_ERR
);
  localparam int kWidth = (numInBits > 1) ? $clog2(numInBits) : 1;

  typedef enum logic {ACCUM, STALL} state_t;

  state_t                             state;
  logic [kWidth-1:0]                  k;
  logic [numCols-1:0][accWidth-1:0]   acc, nxt, result;
  logic [numCols-1:0]                 err;
  logic                               accept, last, res_free, sub;

  assign ADC_READY = (state == ACCUM);
  assign accept    = ADC_VALID && ADC_READY;
  assign last      = (k == kWidth'(numInBits-1));
  assign res_free  = !RESULT_VALID || RESULT_READY;
  assign sub       = SIGNED_IN && last;
  assign RESULT    = result;

  for (genvar j = 0; j < numCols; j++) begin : g_lane
    ts_adc_lane #(
      .numAdcBits(numAdcBits), .numInBits(numInBits), .kWidth(kWidth)
    ) u_lane (
      .code (ADC_OUT[j*compCount +: compCount]),
      .acc  (acc[j]),
      .k    (k),
      .first(k == '0),
      .sub  (sub),
      .nxt  (nxt[j]),
      .err  (err[j])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ACCUM;
      k            <= '0;
      acc          <= '0;
      result       <= '0;
      RESULT_VALID <= 1'b0;
      THERM_ERR    <= 1'b0;
    end else begin
      if (accept && |err) THERM_ERR <= 1'b1;

      // result register: a fresh or held sum reloads it, else consume drains it
      if (!CLR && accept && last && res_free) begin
        result       <= nxt;
        RESULT_VALID <= 1'b1;
      end else if (!CLR && state == STALL && RESULT_READY) begin
        result       <= acc;
        RESULT_VALID <= 1'b1;
      end else if (RESULT_READY) begin
        RESULT_VALID <= 1'b0;
      end

      if (CLR) begin
        state <= ACCUM;
        k     <= '0;
        acc   <= '0;
      end else begin
        case (state)
          ACCUM: if (accept) begin
            if (last) begin
              k <= '0;
              if (!res_free) begin
                acc   <= nxt;
                state <= STALL;
              end
            end else begin
              acc <= nxt;
              k   <= k + kWidth'(1);
            end
          end
          STALL: if (RESULT_READY) begin
            state <= ACCUM;
            k     <= '0;
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ts_adc_accum.sv
// Randomized self-checking bench for ts_adc_accum against a frame-level sum model.

module tb_ts_adc_accum;
  localparam int NC = 8, AB = 4, IB = 4, CC = 15, AW = 8;

  logic              CLK = 1'b0, RST, ADC_VALID, ADC_READY, SIGNED_IN, CLR;
  logic              RESULT_VALID, RESULT_READY, THERM_ERR;
  logic [CC*NC-1:0]  ADC_OUT;
  logic [AW*NC-1:0]  RESULT;

  int errors = 0, checks = 0;
  logic [CC-1:0] fr_code [NC][IB];
  bit            fr_sgn;
  int            exp_res [NC];

  ts_adc_accum #(.numCols(NC), .numAdcBits(AB), .numInBits(IB)) dut (
    .CLK(CLK), .RST(RST), .ADC_OUT(ADC_OUT), .ADC_VALID(ADC_VALID),
    .ADC_READY(ADC_READY), .SIGNED_IN(SIGNED_IN), .CLR(CLR), .RESULT(RESULT),
    .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY), .THERM_ERR(THERM_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [CC-1:0] therm(input int n);
    return CC'((1 << n) - 1);
  endfunction

  // frame sum: sum over planes of (ones - 8) * 2^k, MSB plane negated when signed
  function automatic int model(input int j);
    int s = 0;
    for (int k = 0; k < IB; k++) begin
      int w = ($countones(fr_code[j][k]) - 8) * (1 << k);
      if (fr_sgn && k == IB-1) s -= w; else s += w;
    end
    return s;
  endfunction

  task automatic fill(input int n, input bit s);
    for (int j = 0; j < NC; j++) for (int k = 0; k < IB; k++) fr_code[j][k] = therm(n);
    fr_sgn = s;
  endtask

  task automatic fill_rand();
    for (int j = 0; j < NC; j++)
      for (int k = 0; k < IB; k++) fr_code[j][k] = therm($urandom_range(0, 15));
    fr_sgn = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int k);
    int n = 0;
    for (int j = 0; j < NC; j++) ADC_OUT[j*CC +: CC] = fr_code[j][k];
    SIGNED_IN = (k == IB-1) ? fr_sgn : 1'($urandom_range(0, 1));
    ADC_VALID = 1'b1;
    while (!ADC_READY && n < 20) begin @(posedge CLK); #1; n++; end
    if (!ADC_READY) begin
      checks++; errors++;
      $display("FAIL send_timeout plane=%0d ready=%b required 1", k, ADC_READY);
    end
    @(posedge CLK); #1;
    ADC_VALID = 1'b0;
  endtask

  task automatic drive_frame(input bit rr_last);
    for (int k = 0; k < IB; k++) begin
      if (k == IB-1) RESULT_READY = rr_last;
      send(k);
      RESULT_READY = 1'b0;
    end
    for (int j = 0; j < NC; j++) exp_res[j] = model(j);
  endtask

  task automatic consume();
    RESULT_READY = 1'b1;
    @(posedge CLK); #1;
    RESULT_READY = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ADC_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ADC_READY); end
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL reset_rv got=%b want=0", RESULT_VALID); end
    checks++; if (RESULT !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", RESULT); end
    checks++; if (THERM_ERR !== 1'b0) begin errors++; $display("FAIL reset_therm got=%b want=0", THERM_ERR); end
  endtask

  task automatic test_unsigned_full();
    fill(15, 1'b0);
    for (int k = 0; k < IB-1; k++) send(k);
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL early_rv got=%b want=0", RESULT_VALID); end
    send(IB-1);
    checks++; if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL latency_rv got=%b want=1", RESULT_VALID); end
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== 105) begin errors++; $display("FAIL unsigned_full col=%0d got=%0d want=105", j, got); end
    end
    consume();
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL consume_rv got=%b want=0", RESULT_VALID); end
  endtask

  task automatic test_signed();
    for (int t = 0; t < 2; t++) begin
      int want = (t == 0) ? 8 : 113;
      fill(t == 0 ? 0 : 15, 1'b1);
      if (t == 1) for (int j = 0; j < NC; j++) fr_code[j][IB-1] = '0;
      drive_frame(1'b0);
      for (int j = 0; j < NC; j++) begin
        int got = $signed(RESULT[j*AW +: AW]);
        checks++; if (got !== want) begin errors++; $display("FAIL signed_%0d col=%0d got=%0d want=%0d", t, j, got, want); end
      end
      consume();
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      fill_rand();
      drive_frame(1'b0);
      checks++; if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL random_rv frame=%0d got=%b want=1", f, RESULT_VALID); end
      for (int j = 0; j < NC; j++) begin
        int got = $signed(RESULT[j*AW +: AW]);
        checks++; if (got !== exp_res[j]) begin errors++; $display("FAIL random frame=%0d col=%0d got=%0d want=%0d", f, j, got, exp_res[j]); end
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int a [NC];
    fill_rand(); drive_frame(1'b0);
    a = exp_res;
    fill_rand(); drive_frame(1'b0);
    repeat (2) begin
      checks++; if (ADC_READY !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b want=0", ADC_READY); end
      checks++; if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL stall_rv got=%b want=1", RESULT_VALID); end
      for (int j = 0; j < NC; j++) begin
        int got = $signed(RESULT[j*AW +: AW]);
        checks++; if (got !== a[j]) begin errors++; $display("FAIL stall_hold col=%0d got=%0d want=%0d", j, got, a[j]); end
      end
      @(posedge CLK); #1;
    end
    consume();
    checks++; if (ADC_READY !== 1'b1) begin errors++; $display("FAIL unstall_ready got=%b want=1", ADC_READY); end
    checks++; if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL unstall_rv got=%b want=1", RESULT_VALID); end
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== exp_res[j]) begin errors++; $display("FAIL unstall col=%0d got=%0d want=%0d", j, got, exp_res[j]); end
    end
    fill_rand(); drive_frame(1'b1);
    checks++; if (RESULT_VALID !== 1'b1 || ADC_READY !== 1'b1) begin
      errors++; $display("FAIL same_cycle_flags rv=%b ready=%b want 1 1", RESULT_VALID, ADC_READY); end
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== exp_res[j]) begin errors++; $display("FAIL same_cycle col=%0d got=%0d want=%0d", j, got, exp_res[j]); end
    end
    consume();
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL drain_rv got=%b want=0", RESULT_VALID); end
  endtask

  task automatic test_therm();
    fill(8, 1'b0); drive_frame(1'b0);
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== 0) begin errors++; $display("FAIL mid_code col=%0d got=%0d want=0", j, got); end
    end
    checks++; if (THERM_ERR !== 1'b0) begin errors++; $display("FAIL therm_clean got=%b want=0", THERM_ERR); end
    consume();
    for (int j = 0; j < NC; j++) for (int k = 0; k < IB; k++) fr_code[j][k] = 15'h4000;
    drive_frame(1'b0);
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== -105) begin errors++; $display("FAIL bad_code col=%0d got=%0d want=-105", j, got); end
    end
    checks++; if (THERM_ERR !== 1'b1) begin errors++; $display("FAIL therm_set got=%b want=1", THERM_ERR); end
    consume();
    fill_rand(); drive_frame(1'b0); consume();
    checks++; if (THERM_ERR !== 1'b1) begin errors++; $display("FAIL therm_sticky got=%b want=1", THERM_ERR); end
    RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
    checks++; if (THERM_ERR !== 1'b0) begin errors++; $display("FAIL therm_rst got=%b want=0", THERM_ERR); end
  endtask

  task automatic test_clr();
    fill(15, 1'b0); drive_frame(1'b0);
    fill_rand(); send(0); send(1);
    CLR = 1'b1; @(posedge CLK); #1; CLR = 1'b0;
    checks++; if (RESULT_VALID !== 1'b1) begin errors++; $display("FAIL clr_keeps_rv got=%b want=1", RESULT_VALID); end
    checks++; if ($signed(RESULT[AW-1:0]) !== 8'sd105) begin errors++; $display("FAIL clr_keeps_result got=%0d want=105", $signed(RESULT[AW-1:0])); end
    consume();
    fill(15, 1'b0); drive_frame(1'b0);
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== 105) begin errors++; $display("FAIL clr_abort col=%0d got=%0d want=105", j, got); end
    end
    consume();
    send(0);
    ADC_OUT = '0; ADC_VALID = 1'b1; CLR = 1'b1;
    @(posedge CLK); #1;
    ADC_VALID = 1'b0; CLR = 1'b0;
    for (int k = 0; k < IB-1; k++) send(k);
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL clr_sample_early got=%b want=0", RESULT_VALID); end
    send(IB-1);
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== 105) begin errors++; $display("FAIL clr_sample col=%0d got=%0d want=105", j, got); end
    end
    consume();
  endtask

  task automatic test_rst_mid();
    fill_rand(); drive_frame(1'b0);
    fill_rand(); send(0); send(1);
    #2 RST = 1'b1;
    #1;
    checks++; if (RESULT_VALID !== 1'b0) begin errors++; $display("FAIL rst_mid_rv got=%b want=0", RESULT_VALID); end
    checks++; if (RESULT !== '0) begin errors++; $display("FAIL rst_mid_result got=%h want=0", RESULT); end
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (ADC_READY !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b want=1", ADC_READY); end
    fill_rand(); drive_frame(1'b0);
    for (int j = 0; j < NC; j++) begin
      int got = $signed(RESULT[j*AW +: AW]);
      checks++; if (got !== exp_res[j]) begin errors++; $display("FAIL rst_mid_frame col=%0d got=%0d want=%0d", j, got, exp_res[j]); end
    end
    consume();
  endtask

  initial begin
    RST = 1'b1; ADC_VALID = 1'b0; ADC_OUT = '0; SIGNED_IN = 1'b0; CLR = 1'b0; RESULT_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    test_reset();
    test_unsigned_full();
    test_signed();
    test_random();
    test_back_to_back();
    test_therm();
    test_clr();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
